instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameter: IMEM_SIZE, default 4096; instruction-memory size in bytes.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: pc_load  in  1  request to start a fetch at pc_in.
REQ-005 Port: pc_in  in  64  byte address of the next instruction.
REQ-006 Port: imem_req  out  1  word-read request to instruction memory.
REQ-007 Port: imem_addr  out  64  8-byte-aligned word address; low 3 bits always 0.
REQ-008 Port: imem_ack  in  1  read complete; imem_rdata and imem_rerr are valid in this cycle.
REQ-009 Port: imem_rdata  in  64  little-endian word; byte at the lowest address is in [7:0].
REQ-010 Port: imem_rerr  in  1  memory-side read error.
REQ-011 Port: instr_bytes  out  80  10-byte window at instr_pc; Byte0 is [7:0], Byte9 is [79:72].
REQ-012 Port: instr_pc  out  64  address of Byte0.
REQ-013 Port: instr_valid  out  1  window is ready for the split/decode stage.
REQ-014 Port: instr_ready  in  1  downstream accepts the window.
REQ-015 Port: imem_err  out  1  fetch error; qualified by instr_valid.

Function
REQ-016 States: START, FETCH, HOLD, IDLE, DRAIN.
- START lasts one cycle after reset and loads pc=0 into FETCH.
REQ-017 FETCH: off = pc[2:0].
- Word count is 2 if off<=6, otherwise 3.
- Words are read in order from {pc[63:3],3'b000}, each at +8.
REQ-018 Handshake:
- imem_req is held high and imem_addr held stable until imem_ack is sampled high.
- The next word may be requested in the cycle after the ack.
REQ-019 Assembly: the bytes from each acknowledged word are shifted into a 24-byte buffer; instr_bytes = buffer bytes [off .. off+9].
REQ-020 When the last word is acknowledged, the block moves to HOLD and asserts instr_valid in the next cycle. Minimum latency from entering FETCH to instr_valid is 2 words x 2 cycles.
REQ-021 Error handling:
- If imem_rerr is high with an ack, fetching stops.
- The block enters HOLD with imem_err=1 and instr_bytes=0.
- Any remaining words are not requested.
REQ-022 HOLD:
- instr_valid, instr_bytes, instr_pc and imem_err stay stable until instr_valid&instr_ready.
- The block then enters IDLE with instr_valid=0.
REQ-023 IDLE: the block waits for pc_load, then latches pc_in and enters FETCH in the next cycle.
REQ-024 pc_load in HOLD: the window is discarded (instr_valid drops next cycle) and a new FETCH starts, even if instr_ready is high in the same cycle. The load wins and no transfer is counted.
REQ-025 pc_load in FETCH:
- With no request outstanding: restart immediately at pc_in.
- With imem_req high and no ack yet: enter DRAIN, keep the request until ack, discard the data, then enter FETCH at the latched pc_in.
- A second pc_load during DRAIN overwrites the latched pc.
REQ-026 pc_load in START: pc_in overrides the reset pc of 0.
REQ-027 No wrap-around: addresses beyond 2^64-1 are not generated. Word address increments are plain 64-bit adds.

Reset
REQ-028 When rst_n is low, all outputs clear immediately:
- imem_req=0, imem_addr=0
- instr_valid=0, imem_err=0
- instr_bytes=0, instr_pc=0
REQ-029 Reset state:
- state=START, buffer cleared, latched pc=0.
- An outstanding memory request is abandoned; any ack arriving after reset is ignored.

Configuration
REQ-030 Macro IMEM_BOUNDS_CHECK_EN.
- Defined: before each word request, if word address >= IMEM_SIZE, no request is issued. The block enters HOLD with imem_err=1 and instr_bytes=0, as if imem_rerr had been returned.
- Not defined: imem_err is driven only by imem_rerr, and every address is requested.

Verification
REQ-031 Reset release, memory acks after 1 cycle, word0=0x0706050403020100, word8=0x0F0E0D0C0B0A0908 -> instr_bytes=0x09080706050403020100, instr_pc=0, imem_err=0.
REQ-032 pc_load pc_in=0x0F -> requests 0x08, 0x10, 0x18 in order; instr_bytes = byte 0x0F through byte 0x18.
REQ-033 imem_rerr=1 on the second ack of pc_in=0x20 -> no third request; instr_valid=1, imem_err=1, instr_bytes=0.
REQ-034 pc_load while a request at 0x40 is outstanding with a 5-cycle ack delay -> request held until ack, data discarded; next request to the new pc's word.
REQ-035 HOLD with instr_ready low for 10 cycles -> outputs stable. pc_load and instr_ready high in the same cycle -> new fetch starts; the old window is not transferred.
REQ-036 With IMEM_BOUNDS_CHECK_EN and IMEM_SIZE=4096, pc_in=0xFFC -> word 0xFF8 requested, no request at 0x1000; result imem_err=1. Without the macro, 0x1000 is requested.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: reads 2-3 aligned 64-bit words and presents the 10-byte window at pc.
// Latency: at least 4 cycles from FETCH entry to instr_valid; the window is held until instr_ready or pc_load.
// Backpressure: imem_req/imem_addr are held until imem_ack. Optional IMEM_BOUNDS_CHECK_EN blocks words >= IMEM_SIZE.
module instr_fetch_buffer #(
    parameter int unsigned IMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    input  logic        imem_rerr,
    output logic [79:0] instr_bytes,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        imem_err
);
    typedef enum logic [2:0] {START, FETCH, HOLD, IDLE, DRAIN} state_t;

    state_t       state, state_nxt;
    logic [63:0]  pc, drain_pc, new_pc, issue_addr;
    logic [191:0] buffer, buf_mrg;
    logic [79:0]  window;
    logic [1:0]   widx, nwords;
    logic         load_pc, issue, store, done, fail, bounds_en;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign bounds_en = 1'b1;
`else
    assign bounds_en = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        load_pc    = 1'b0;
        new_pc     = pc_in;
        issue      = 1'b0;
        issue_addr = imem_addr + 64'd8;
        store      = 1'b0;
        done       = 1'b0;
        fail       = 1'b0;
        case (state)
            START: begin
                load_pc   = 1'b1;
                new_pc    = pc_load ? pc_in : 64'd0;
                issue     = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: begin
                if (pc_load && imem_req && !imem_ack) begin
                    state_nxt = DRAIN;
                end else if (pc_load) begin
                    load_pc = 1'b1;
                    issue   = 1'b1;
                end else if (imem_req && imem_ack) begin
                    store = 1'b1;
                    if (imem_rerr) begin
                        fail      = 1'b1;
                        state_nxt = HOLD;
                    end else if (widx == nwords - 2'd1) begin
                        done      = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The abandoned word's data is dropped; the newest pc_in wins.
                if (imem_ack) begin
                    load_pc   = 1'b1;
                    new_pc    = pc_load ? pc_in : drain_pc;
                    issue     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (pc_load) begin
                    load_pc   = 1'b1;
                    issue     = 1'b1;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (pc_load) begin
                    load_pc   = 1'b1;
                    issue     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = START;
        endcase
        if (load_pc) begin
            issue_addr = {new_pc[63:3], 3'b000};
        end
        // An out-of-range word is reported exactly like a memory read error.
        if (issue && bounds_en && (issue_addr >= 64'(IMEM_SIZE))) begin
            issue     = 1'b0;
            fail      = 1'b1;
            state_nxt = HOLD;
        end
    end

    always_comb begin
        buf_mrg = buffer;
        if (store) begin
            buf_mrg[{widx, 6'b000000} +: 64] = imem_rdata;
        end
        window = buf_mrg[{2'b00, pc[2:0], 3'b000} +: 80];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= START;
            pc          <= '0;
            drain_pc    <= '0;
            buffer      <= '0;
            widx        <= '0;
            nwords      <= 2'd2;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            imem_err    <= 1'b0;
            instr_bytes <= '0;
            instr_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (load_pc) begin
                pc     <= new_pc;
                buffer <= '0;
                widx   <= '0;
                nwords <= (new_pc[2:0] == 3'd7) ? 2'd3 : 2'd2;
            end else if (store) begin
                buffer <= buf_mrg;
                widx   <= widx + 2'd1;
            end
            if (pc_load && (state_nxt == DRAIN)) begin
                drain_pc <= pc_in;
            end
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= issue_addr;
            end else if (imem_ack) begin
                imem_req <= 1'b0;
            end
            if (done || fail) begin
                instr_valid <= 1'b1;
                imem_err    <= fail;
                instr_bytes <= fail ? '0 : window;
                instr_pc    <= load_pc ? new_pc : pc;
            end else if ((state == HOLD) && (pc_load || instr_ready)) begin
                instr_valid <= 1'b0;
                imem_err    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: memory model returns byte k of word A as (A+k)[7:0].
module tb_instr_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pc_load = 1'b0;
    logic [63:0] pc_in = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_rdata = '0;
    logic        imem_rerr = 1'b0;
    logic [79:0] instr_bytes;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        imem_err;

    int          checks = 0;
    int          errors = 0;
    int          mem_dly = 1;
    int          mem_cnt = 0;
    int          n;
    logic [63:0] err_addr = '1;
    logic [63:0] req_log[$];

    localparam logic [79:0] WIN0   = 80'h09080706050403020100;
    localparam logic [79:0] WIN0F  = 80'h1817161514131211100F;
    localparam logic [79:0] WIN10  = 80'h19181716151413121110;
    localparam logic [79:0] WINFFC = 80'h0504030201_00FFFEFDFC;

    instr_fetch_buffer #(.IMEM_SIZE(4096)) dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_in(pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_rerr(imem_rerr),
        .instr_bytes(instr_bytes), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .imem_err(imem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(a + 64'(k));
        return w;
    endfunction

    function automatic logic [63:0] log_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    task automatic load(input logic [63:0] a);
        pc_load = 1'b1;
        pc_in   = a;
        step();
        pc_load = 1'b0;
    endtask

    task automatic release_win();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    // Memory: acks mem_dly cycles after a request is first seen, one-cycle ack pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                imem_ack  = 1'b0;
                imem_rerr = 1'b0;
                mem_cnt   = 0;
            end else begin
                if (imem_ack) begin
                    imem_ack  = 1'b0;
                    imem_rerr = 1'b0;
                    mem_cnt   = 0;
                end
                if (imem_req) begin
                    mem_cnt++;
                    if (mem_cnt == 1) req_log.push_back(imem_addr);
                    if (mem_cnt > mem_dly) begin
                        imem_ack   = 1'b1;
                        imem_rerr  = (imem_addr == err_addr);
                        imem_rdata = word_at(imem_addr);
                    end
                end else begin
                    mem_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_err", imem_err, 0);
        chk("rst_bytes", instr_bytes, 0);
        chk("rst_pc", instr_pc, 0);
        step();
        step();
        rst_n = 1'b1;

        // Boot fetch at pc 0
        wait_valid(50, n);
        chk("boot_latency", n, 5);
        chk("boot_valid", instr_valid, 1);
        chk("boot_bytes", instr_bytes, WIN0);
        chk("boot_pc", instr_pc, 0);
        chk("boot_err", imem_err, 0);
        chk("boot_nreq", req_log.size(), 2);
        chk("boot_req1", log_at(1), 64'h8);

        // Window held while downstream stalls
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", instr_valid, 1);
            chk("hold_bytes", instr_bytes, WIN0);
        end
        release_win();
        chk("rel_valid", instr_valid, 0);
        step();
        chk("idle_req", imem_req, 0);

        // Three-word fetch at offset 7
        req_log.delete();
        load(64'h0F);
        wait_valid(50, n);
        chk("off7_valid", instr_valid, 1);
        chk("off7_nreq", req_log.size(), 3);
        chk("off7_req0", log_at(0), 64'h08);
        chk("off7_req1", log_at(1), 64'h10);
        chk("off7_req2", log_at(2), 64'h18);
        chk("off7_bytes", instr_bytes, WIN0F);
        chk("off7_pc", instr_pc, 64'h0F);
        release_win();

        // Read error on second word
        err_addr = 64'h28;
        req_log.delete();
        load(64'h20);
        wait_valid(50, n);
        chk("rerr_valid", instr_valid, 1);
        chk("rerr_err", imem_err, 1);
        chk("rerr_bytes", instr_bytes, 0);
        chk("rerr_nreq", req_log.size(), 2);
        release_win();
        req_log.delete();
        load(64'h27);
        wait_valid(50, n);
        step();
        step();
        step();
        chk("rerr3_err", imem_err, 1);
        chk("rerr3_bytes", instr_bytes, 0);
        chk("rerr3_req", imem_req, 0);
        chk("rerr3_nreq", req_log.size(), 2);
        err_addr = '1;

        // Asynchronous reset while holding an error window; pc_load during START
        rst_n = 1'b0;
        #1;
        chk("arst_valid", instr_valid, 0);
        chk("arst_err", imem_err, 0);
        chk("arst_pc", instr_pc, 0);
        step();
        req_log.delete();
        pc_load = 1'b1;
        pc_in   = 64'h10;
        rst_n   = 1'b1;
        step();
        pc_load = 1'b0;
        wait_valid(50, n);
        chk("start_req0", log_at(0), 64'h10);
        chk("start_pc", instr_pc, 64'h10);
        chk("start_bytes", instr_bytes, WIN10);
        release_win();

        // Redirect while a slow request is outstanding, then redirect again in DRAIN
        mem_dly = 5;
        req_log.delete();
        pc_load = 1'b1;
        pc_in   = 64'h40;
        step();
        pc_in   = 64'h100;
        step();
        pc_in   = 64'h200;
        step();
        pc_load = 1'b0;
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 64'h40);
        wait_valid(100, n);
        chk("drain_valid", instr_valid, 1);
        chk("drain_nreq", req_log.size(), 3);
        chk("drain_req1", log_at(1), 64'h200);
        chk("drain_req2", log_at(2), 64'h208);
        chk("drain_pc", instr_pc, 64'h200);
        chk("drain_bytes", instr_bytes, WIN0);
        mem_dly = 1;
        release_win();

        // pc_load beats instr_ready in HOLD
        load(64'h300);
        wait_valid(50, n);
        chk("ldr_hold", instr_valid, 1);
        req_log.delete();
        pc_load     = 1'b1;
        pc_in       = 64'h0;
        instr_ready = 1'b1;
        step();
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        chk("ldr_valid", instr_valid, 0);
        chk("ldr_req", imem_req, 1);
        chk("ldr_addr", imem_addr, 0);
        wait_valid(50, n);
        chk("ldr_pc", instr_pc, 0);
        chk("ldr_bytes", instr_bytes, WIN0);
        release_win();

        // Fetch straddling the end of instruction memory
        req_log.delete();
        load(64'hFFC);
        wait_valid(50, n);
        chk("bnd_valid", instr_valid, 1);
        chk("bnd_req0", log_at(0), 64'hFF8);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("bnd_nreq", req_log.size(), 1);
        chk("bnd_err", imem_err, 1);
        chk("bnd_bytes", instr_bytes, 0);
`else
        chk("bnd_nreq", req_log.size(), 2);
        chk("bnd_req1", log_at(1), 64'h1000);
        chk("bnd_err", imem_err, 0);
        chk("bnd_bytes", instr_bytes, WINFFC);
`endif
        release_win();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
